// File: rtl/boreal_action_arbiter.sv
// ---------------------------------------------------------------------------
// boreal_action_arbiter
//
// Round-robin arbiter that funnels action requests from N_REQ Decision VM
// instances into the single action port of the Gate. One transaction at a
// time: pick a requester, present its latched payload to the Gate, wait for
// the Gate to accept (gate_ready falls) and complete (gate_ready rises), then
// hand the completion back to the granted requester as a low pulse on its
// rq_ready.
//
// Handshake semantics (both sides): a ready line that is high means "idle,
// able to take an action". The consumer drops ready to accept an action and
// raises it again on completion, so an accept/complete pair shows up as a low
// pulse on ready. Toward the Gate, gate_valid is held from the cycle after
// the pick until the Gate's ready is sampled low (accept) or the accept
// timeout expires. Toward the requesters, only the granted requester's
// rq_ready ever goes low; everyone else sees a constant 1 and keeps waiting.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   arb_enable                  1 = new picks allowed (in-flight work always finishes)
//   rq_valid[N_REQ]             per-requester request
//   rq_opcode/target/arg0/arg1  per-requester payload, requester i at [32i+31:32i]
//   rq_ready[N_REQ]             per-requester ready (low pulse = accept/complete)
//   gate_valid                  action valid toward the Gate
//   gate_opcode/target/arg0/arg1 payload latched at the pick
//   gate_ready                  Gate ready
//   grant_id                    current or last granted requester
//   busy                        any state other than IDLE
//   err_timeout                 sticky accept-timeout flag, cleared only by reset
//   grant_count                 completed (non-timeout) grants, saturating
//   state_dbg                   current FSM state for observation
// ---------------------------------------------------------------------------
module boreal_action_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 arb_enable,
    input  logic [N_REQ-1:0]     rq_valid,
    input  logic [N_REQ*32-1:0]  rq_opcode,
    input  logic [N_REQ*32-1:0]  rq_target,
    input  logic [N_REQ*32-1:0]  rq_arg0,
    input  logic [N_REQ*32-1:0]  rq_arg1,
    output logic [N_REQ-1:0]     rq_ready,
    output logic                 gate_valid,
    output logic [31:0]          gate_opcode,
    output logic [31:0]          gate_target,
    output logic [31:0]          gate_arg0,
    output logic [31:0]          gate_arg1,
    input  logic                 gate_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [15:0]          grant_count,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_DONE = 2'd2;
    localparam logic [1:0] S_RELEASE   = 2'd3;

    logic [1:0]  state;
    logic [2:0]  last_grant;
    logic [15:0] tmo_cnt;
    logic        timed_out;   // current transaction ended by timeout

    // Payloads unpacked into 8-entry arrays so a 3-bit index always fits,
    // independent of N_REQ. Unused slots read as zero and are never picked.
    logic [31:0] op_arr  [8];
    logic [31:0] tgt_arr [8];
    logic [31:0] a0_arr  [8];
    logic [31:0] a1_arr  [8];
    logic [7:0]  valid_pad;

    for (genvar i = 0; i < 8; i++) begin : g_unpack
        if (i < N_REQ) begin : g_used
            assign op_arr[i]  = rq_opcode[32*i +: 32];
            assign tgt_arr[i] = rq_target[32*i +: 32];
            assign a0_arr[i]  = rq_arg0[32*i +: 32];
            assign a1_arr[i]  = rq_arg1[32*i +: 32];
        end else begin : g_unused
            assign op_arr[i]  = '0;
            assign tgt_arr[i] = '0;
            assign a0_arr[i]  = '0;
            assign a1_arr[i]  = '0;
        end
    end

    assign valid_pad = 8'(rq_valid);

    // Round-robin search starting at last_grant+1 with wrap. The loop runs
    // from the farthest candidate to the nearest so the nearest valid
    // requester overwrites any earlier hit.
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = 3'((int'(last_grant) + k) % N_REQ);
            if (valid_pad[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Only the granted requester ever sees ready low: through WAIT_DONE, and
    // for the single RELEASE cycle after a timeout (the synthetic completion
    // pulse that keeps it from deadlocking).
    always_comb begin
        rq_ready = '1;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == 3'(i) &&
                (state == S_WAIT_DONE || (state == S_RELEASE && timed_out))) begin
                rq_ready[i] = 1'b0;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_grant  <= 3'(N_REQ - 1);
            tmo_cnt     <= '0;
            timed_out   <= 1'b0;
            gate_valid  <= 1'b0;
            gate_opcode <= '0;
            gate_target <= '0;
            gate_arg0   <= '0;
            gate_arg1   <= '0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            grant_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_enable && gate_ready && pick_found) begin
                        gate_opcode <= op_arr[pick_idx];
                        gate_target <= tgt_arr[pick_idx];
                        gate_arg0   <= a0_arr[pick_idx];
                        gate_arg1   <= a1_arr[pick_idx];
                        grant_id    <= pick_idx;
                        tmo_cnt     <= '0;
                        timed_out   <= 1'b0;
                        gate_valid  <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!gate_ready) begin
                        // Gate accepted the action.
                        gate_valid <= 1'b0;
                        state      <= S_WAIT_DONE;
                    end else if (tmo_cnt == 16'(TIMEOUT)) begin
                        gate_valid  <= 1'b0;
                        err_timeout <= 1'b1;
                        timed_out   <= 1'b1;
                        state       <= S_RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (gate_ready) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    last_grant <= grant_id;
                    if (!timed_out && grant_count != 16'hFFFF) begin
                        grant_count <= grant_count + 16'd1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boreal_action_arbiter.sv
// ---------------------------------------------------------------------------
// tb_boreal_action_arbiter
//
// Self-checking bench for boreal_action_arbiter (N_REQ=4, TIMEOUT=4).
// Expected grants ({grant_id, opcode}) are queued when requests are driven
// and compared when gate_valid appears. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_boreal_action_arbiter;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic            clk;
    logic            rst_n;
    logic            arb_enable;
    logic [N-1:0]    rq_valid;
    logic [N*32-1:0] rq_opcode;
    logic [N*32-1:0] rq_target;
    logic [N*32-1:0] rq_arg0;
    logic [N*32-1:0] rq_arg1;
    logic [N-1:0]    rq_ready;
    logic            gate_valid;
    logic [31:0]     gate_opcode;
    logic [31:0]     gate_target;
    logic [31:0]     gate_arg0;
    logic [31:0]     gate_arg1;
    logic            gate_ready;
    logic [2:0]      grant_id;
    logic            busy;
    logic            err_timeout;
    logic [15:0]     grant_count;
    logic [1:0]      state_dbg;

    int total = 0;
    int bad   = 0;

    logic [34:0] exp_q[$];

    boreal_action_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_enable  (arb_enable),
        .rq_valid    (rq_valid),
        .rq_opcode   (rq_opcode),
        .rq_target   (rq_target),
        .rq_arg0     (rq_arg0),
        .rq_arg1     (rq_arg1),
        .rq_ready    (rq_ready),
        .gate_valid  (gate_valid),
        .gate_opcode (gate_opcode),
        .gate_target (gate_target),
        .gate_arg0   (gate_arg0),
        .gate_arg1   (gate_arg1),
        .gate_ready  (gate_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_timeout (err_timeout),
        .grant_count (grant_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        gate_ready = 1'b1;
        arb_enable = 1'b1;
        rq_valid   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic set_payload(input int i, input logic [31:0] op);
        rq_opcode[32*i +: 32] = op;
        rq_target[32*i +: 32] = op ^ 32'h5555_0000;
        rq_arg0[32*i +: 32]   = ~op;
        rq_arg1[32*i +: 32]   = op + 32'd1;
    endtask

    // Plays the Gate for one transaction: waits for gate_valid, checks the
    // scoreboard, accepts, holds ready low for low_cycles, completes, and
    // checks the requester-side ready pulse.
    task automatic run_txn(input int low_cycles, input bit scramble);
        int          t;
        int          lows;
        int          idx;
        bit          others_bad;
        logic [34:0] exp;
        t = 0;
        while (gate_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (gate_valid !== 1'b1) begin
            $display("FAIL txn_start: gate_valid=%b required 1 within 40 cycles", gate_valid);
            bad++;
            return;
        end
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: grant %0d seen with no expectation", grant_id);
            bad++;
            return;
        end
        exp = exp_q.pop_front();
        idx = int'(exp[34:32]);
        total++;
        if ({grant_id, gate_opcode} !== exp) begin
            $display("FAIL grant: id=%0d op=%h required id=%0d op=%h",
                     grant_id, gate_opcode, exp[34:32], exp[31:0]);
            bad++;
        end
        if (scramble) begin
            for (int i = 0; i < N; i++) rq_opcode[32*i +: 32] = $urandom();
        end
        gate_ready = 1'b0;
        lows       = 0;
        others_bad = 1'b0;
        for (int c = 0; c < low_cycles; c++) begin
            @(negedge clk);
            if (rq_ready[idx] === 1'b0) lows++;
            if ((rq_ready | (4'b0001 << idx)) !== 4'hF) others_bad = 1'b1;
        end
        gate_ready = 1'b1;
        t = 0;
        while (busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
            if (rq_ready[idx] === 1'b0) lows++;
            if ((rq_ready | (4'b0001 << idx)) !== 4'hF) others_bad = 1'b1;
        end
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL txn_end: busy=%b required 0 within 20 cycles", busy);
            bad++;
        end
        total++;
        if (lows != low_cycles) begin
            $display("FAIL rq_ready_pulse: low for %0d cycles required %0d", lows, low_cycles);
            bad++;
        end
        total++;
        if (others_bad) begin
            $display("FAIL others_ready: a non-granted rq_ready went low, required all 1");
            bad++;
        end
        total++;
        if (gate_opcode !== exp[31:0]) begin
            $display("FAIL payload_hold: gate_opcode=%h required %h", gate_opcode, exp[31:0]);
            bad++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (gate_valid !== 1'b0)   begin $display("FAIL rst_gate_valid: %b required 0", gate_valid); bad++; end
        total++; if (rq_ready !== 4'hF)     begin $display("FAIL rst_rq_ready: %b required 1111", rq_ready); bad++; end
        total++; if (busy !== 1'b0)         begin $display("FAIL rst_busy: %b required 0", busy); bad++; end
        total++; if (err_timeout !== 1'b0)  begin $display("FAIL rst_err: %b required 0", err_timeout); bad++; end
        total++; if (grant_count !== 16'd0) begin $display("FAIL rst_count: %0d required 0", grant_count); bad++; end
        total++; if (grant_id !== 3'd0)     begin $display("FAIL rst_grant_id: %0d required 0", grant_id); bad++; end
        total++; if (gate_opcode !== 32'd0) begin $display("FAIL rst_payload: %h required 0", gate_opcode); bad++; end
        total++; if (state_dbg !== 2'd0)    begin $display("FAIL rst_state: %0d required 0", state_dbg); bad++; end
    endtask

    task automatic test_single();
        set_payload(2, 32'h11);
        rq_valid = 4'b0100;
        exp_q.push_back({3'd2, 32'h11});
        run_txn(2, 1'b1);
        rq_valid = '0;
        total++; if (grant_count !== 16'd1) begin $display("FAIL single_count: %0d required 1", grant_count); bad++; end
        total++; if (grant_id !== 3'd2)     begin $display("FAIL single_id: %0d required 2", grant_id); bad++; end
        total++;
        if (gate_target !== (32'h11 ^ 32'h5555_0000)) begin
            $display("FAIL single_target: %h required %h", gate_target, 32'h11 ^ 32'h5555_0000);
            bad++;
        end
    endtask

    task automatic test_contention();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) set_payload(i, 32'hA0 + 32'(i));
        rq_valid = 4'hF;
        for (int k = 0; k < 5; k++) exp_q.push_back({3'(order[k]), 32'hA0 + 32'(order[k])});
        for (int k = 0; k < 5; k++) run_txn(1 + (k % 2), 1'b0);
        rq_valid = '0;
        total++; if (grant_count !== 16'd5) begin $display("FAIL contention_count: %0d required 5", grant_count); bad++; end
    endtask

    task automatic test_timeout();
        int          t;
        int          hi;
        int          lows;
        logic [34:0] exp;
        total++; if (err_timeout !== 1'b0) begin $display("FAIL pre_timeout_err: %b required 0", err_timeout); bad++; end
        set_payload(3, 32'h33);
        rq_valid = 4'b1000;
        exp_q.push_back({3'd3, 32'h33});
        t = 0;
        while (gate_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        rq_valid = '0;
        exp = exp_q.pop_front();
        total++;
        if ({grant_id, gate_opcode} !== exp) begin
            $display("FAIL timeout_grant: id=%0d op=%h required id=%0d op=%h",
                     grant_id, gate_opcode, exp[34:32], exp[31:0]);
            bad++;
        end
        hi = (gate_valid === 1'b1) ? 1 : 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gate_valid !== 1'b1) break;
            hi++;
        end
        lows = (rq_ready[3] === 1'b0) ? 1 : 0;
        t = 0;
        while (busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
            if (rq_ready[3] === 1'b0) lows++;
        end
        total++; if (hi != TMO + 1)         begin $display("FAIL timeout_valid_len: %0d required %0d", hi, TMO + 1); bad++; end
        total++; if (lows != 1)             begin $display("FAIL timeout_pulse: low %0d cycles required 1", lows); bad++; end
        total++; if (err_timeout !== 1'b1)  begin $display("FAIL timeout_err: %b required 1", err_timeout); bad++; end
        total++; if (grant_count !== 16'd5) begin $display("FAIL timeout_count: %0d required 5", grant_count); bad++; end
        total++; if (busy !== 1'b0)         begin $display("FAIL timeout_idle: busy=%b required 0", busy); bad++; end
    endtask

    task automatic test_reset_mid();
        int          t;
        logic [34:0] exp;
        set_payload(1, 32'h77);
        rq_valid = 4'b0010;
        exp_q.push_back({3'd1, 32'h77});
        t = 0;
        while (gate_valid !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        exp = exp_q.pop_front();
        total++;
        if ({grant_id, gate_opcode} !== exp) begin
            $display("FAIL mid_grant: id=%0d op=%h required id=%0d op=%h",
                     grant_id, gate_opcode, exp[34:32], exp[31:0]);
            bad++;
        end
        gate_ready = 1'b0;
        @(negedge clk);
        total++; if (rq_ready !== 4'b1101) begin $display("FAIL mid_wait_ready: %b required 1101", rq_ready); bad++; end
        for (int i = 0; i < N; i++) set_payload(i, 32'hC0 + 32'(i));
        rq_valid = 4'hF;
        rst_n    = 1'b0;
        @(negedge clk);
        total++; if (gate_valid !== 1'b0)   begin $display("FAIL mid_gate_valid: %b required 0", gate_valid); bad++; end
        total++; if (rq_ready !== 4'hF)     begin $display("FAIL mid_rq_ready: %b required 1111", rq_ready); bad++; end
        total++; if (busy !== 1'b0)         begin $display("FAIL mid_busy: %b required 0", busy); bad++; end
        total++; if (err_timeout !== 1'b0)  begin $display("FAIL mid_err: %b required 0", err_timeout); bad++; end
        total++; if (grant_count !== 16'd0) begin $display("FAIL mid_count: %0d required 0", grant_count); bad++; end
        total++; if (gate_opcode !== 32'd0) begin $display("FAIL mid_payload: %h required 0", gate_opcode); bad++; end
        gate_ready = 1'b1;
        rst_n      = 1'b1;
        exp_q.push_back({3'd0, 32'hC0});
        run_txn(1, 1'b0);
        rq_valid = '0;
    endtask

    task automatic test_enable();
        bit seen;
        arb_enable = 1'b0;
        set_payload(1, 32'h99);
        rq_valid = 4'b0010;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (gate_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin $display("FAIL enable_block: activity while arb_enable=0, required none"); bad++; end
        exp_q.push_back({3'd1, 32'h99});
        arb_enable = 1'b1;
        @(negedge clk);
        total++; if (gate_valid !== 1'b1) begin $display("FAIL enable_rise: gate_valid=%b required 1", gate_valid); bad++; end
        arb_enable = 1'b0;
        run_txn(3, 1'b0);
        rq_valid = '0;
        total++; if (grant_count !== 16'd2) begin $display("FAIL enable_count: %0d required 2", grant_count); bad++; end
        arb_enable = 1'b1;
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        rst_n      = 1'b0;
        arb_enable = 1'b1;
        gate_ready = 1'b1;
        rq_valid   = '0;
        rq_opcode  = '0;
        rq_target  = '0;
        rq_arg0    = '0;
        rq_arg1    = '0;

        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_enable();

        total++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
            bad++;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boreal_action_arbiter.md
BOREAL_ACTION_ARBITER -- requirements
Module: boreal_action_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4; number of action requesters (Decision VM instances), range 2..8.
REQ-002 SHALL have parameter TIMEOUT, default 255; max cycles in ISSUE waiting for Gate accept, range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port arb_enable  input  1  1 = new grants allowed.
REQ-006 SHALL have port rq_valid  input  N_REQ  per-requester action request.
REQ-007 SHALL have ports rq_opcode, rq_target, rq_arg0, rq_arg1  input  N_REQ*32 each  per-requester payload; requester i occupies bits [32i+31:32i].
REQ-008 SHALL have port rq_ready  output  N_REQ  per-requester ready; same handshake semantics as the Gate's act_ready.
REQ-009 SHALL have port gate_valid  output  1  action valid toward the Gate.
REQ-010 SHALL have ports gate_opcode, gate_target, gate_arg0, gate_arg1  output  32 each  latched payload toward the Gate.
REQ-011 SHALL have port gate_ready  input  1  Gate ready; falls on accept, rises on completion.
REQ-012 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port err_timeout  output  1  sticky; set on Gate accept timeout.
REQ-015 SHALL have port grant_count  output  16  total completed grants, saturating.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_DONE and RELEASE.
REQ-017 IDLE: when arb_enable=1, gate_ready=1 and any rq_valid=1, SHALL pick the requester round-robin, searching from (last_grant+1) mod N_REQ upward with wrap.
- On the pick edge it latches that requester's payload into the gate_* registers, sets grant_id, clears the timeout counter and enters ISSUE.
REQ-018 ISSUE: gate_valid SHALL be 1; gate_valid rises exactly 1 cycle after the pick.
REQ-019 ISSUE, gate_ready sampled 0: SHALL clear gate_valid, drive rq_ready[grant_id]=0 and enter WAIT_DONE.
REQ-020 ISSUE, gate_ready still 1 with the counter equal to TIMEOUT: SHALL clear gate_valid, set err_timeout, drive rq_ready[grant_id]=0 and enter RELEASE.
- The requester therefore observes a one-cycle accept/complete pulse and is not deadlocked.
REQ-021 WAIT_DONE: rq_ready[grant_id] SHALL track 0 until gate_ready=1; it SHALL then be 1, and the block enters RELEASE.
REQ-022 RELEASE (exactly 1 cycle): SHALL set rq_ready all 1, update last_grant=grant_id, increment grant_count (saturate at 16'hFFFF; not incremented on timeout), then enter IDLE.
REQ-023 Non-granted requesters: rq_ready SHALL stay 1 at all times, so their requests wait in the VM accept phase.
REQ-024 gate_* payload SHALL be stable from the pick until the next pick; changes on rq_* after the pick SHALL be ignored.
REQ-025 arb_enable=0 SHALL block only new picks; an in-flight transaction SHALL complete normally.
REQ-026 A request whose rq_valid drops while the requester is not granted SHALL be treated as withdrawn, with no state kept.
REQ-027 Simultaneous requests: exactly one grant per transaction; with all N_REQ requesting continuously, each SHALL be granted once per N_REQ transactions.
REQ-028 The minimum transaction is 5 cycles pick-to-IDLE: pick, ISSUE, WAIT_DONE, RELEASE, IDLE.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force:
- state=IDLE, last_grant=N_REQ-1 (so requester 0 has first priority);
- gate_valid=0, gate_* payload=0, rq_ready all 1, grant_id=0;
- busy=0, err_timeout=0, grant_count=0, timeout counter=0.
REQ-030 Reset in any state, including mid-transaction, SHALL abandon the transaction without a completion pulse; err_timeout is cleared only by reset.

Verification
REQ-031 Single request: rq_valid[2]=1, opcode 0x11 -> gate_valid 1 cycle later with gate_opcode=0x11; Gate drops ready 2 cycles, then raises it -> rq_ready[2] low 2 cycles; grant_count=1; grant_id=2.
REQ-032 Contention: rq_valid=4'b1111 held after reset -> grant order 0,1,2,3,0; rq_ready of each waiting requester stays 1.
REQ-033 Timeout (TIMEOUT=4): gate_ready stuck 1 -> gate_valid high 5 cycles then 0; err_timeout=1; rq_ready[g] low exactly 1 cycle; grant_count unchanged.
REQ-034 Reset mid-op: rst_n=0 in WAIT_DONE -> next cycle gate_valid=0, rq_ready=all 1, busy=0; after release, requester 0 wins first.
REQ-035 Enable gating: arb_enable=0 with rq_valid[1]=1 -> no gate_valid for 20 cycles; arb_enable=1 -> gate_valid the next cycle after the pick; clearing enable mid-ISSUE still completes.
